// File: rtl/iobus_event_reader.sv
// Event-capture RAM reader: tracks the port-A writer by snooping byte enables and
// exposes captured words on the MCS IO bus as a STATUS / DATA-pop / CONTROL FIFO.
module iobus_event_reader #(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0000,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [3:0]            wa_we,
  output logic [DEPTH_LOG2-1:0] rb_addr,
  input  logic [31:0]           rb_dout,
  input  logic                  IO_Addr_Strobe,
  input  logic                  IO_Read_Strobe,
  input  logic                  IO_Write_Strobe,
  input  logic [31:0]           IO_Address,
  input  logic [3:0]            IO_Byte_Enable,
  input  logic [31:0]           IO_Write_Data,
  output logic [31:0]           IO_Read_Data,
  output logic                  IO_Ready
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            wait_q;
  logic [DEPTH_LOG2-1:0] rb_addr_q;
  logic [31:0]           rdata_q;
  logic                  ready_q;

  logic [PW-1:0] count;
  logic [31:0]   status;
  logic [31:0]   read_val;
  logic          we, pop, drop, hit, acc, data_rd, ctrl_wr, flush, clr_ovf;
  logic [1:0]    offs;
  logic          unused_inputs;

  assign unused_inputs = ^{IO_Byte_Enable, IO_Write_Data[31:2], IO_Address[1:0], IO_Write_Strobe};

  assign we      = (wa_we == 4'b1111);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign hit     = (IO_Address[31:4] == BASE_ADDR[31:4]);
  assign offs    = IO_Address[3:2];
  assign acc     = (state_q == S_IDLE) && IO_Addr_Strobe;
  assign data_rd = acc && IO_Read_Strobe && hit && (offs == 2'd1) && (count != '0);
  assign ctrl_wr = acc && !IO_Read_Strobe && hit && (offs == 2'd2);
  assign flush   = ctrl_wr && IO_Write_Data[0];
  assign clr_ovf = ctrl_wr && (IO_Write_Data[0] || IO_Write_Data[1]);
  assign pop     = (state_q == S_WAIT) && (wait_q == 2'd2);
  // A write landing on a full buffer with a simultaneous pop just rotates the window.
  assign drop    = we && (count == FULL) && !pop;

  always_comb begin
    status = '0;
    status[31] = ovf_q;
    status[PW-1:0] = count;
    read_val = (IO_Read_Strobe && hit && (offs == 2'd0)) ? status : '0;
    wr_ptr_d = wr_ptr_q + PW'(we);
    rd_ptr_d = rd_ptr_q;
    if (flush)            rd_ptr_d = wr_ptr_q;
    else if (pop || drop) rd_ptr_d = rd_ptr_q + PW'(1);
    ovf_d = ovf_q;
    if (clr_ovf)   ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
  end

  // wait_q counts cycles since rd_ptr last moved; rb_dout is current once it reaches 2.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      wait_q    <= '0;
      rb_addr_q <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      rb_addr_q <= rd_ptr_q[DEPTH_LOG2-1:0];
      ready_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          rdata_q <= '0;
          if (data_rd) begin
            state_q <= S_WAIT;
            wait_q  <= drop ? 2'd0 : 2'd1;
          end else if (acc) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            rdata_q <= read_val;
          end
        end
        S_WAIT: begin
          if (wait_q == 2'd2) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            rdata_q <= rb_dout;
          end else begin
            wait_q <= drop ? 2'd0 : wait_q + 2'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          rdata_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign rb_addr      = rb_addr_q;
  assign IO_Read_Data = rdata_q;
  assign IO_Ready     = ready_q;

endmodule

// File: tb/tb_iobus_event_reader.sv
// Directed bench for iobus_event_reader: models the capture RAM and drives MCS IO-bus accesses.
module tb_iobus_event_reader;

  localparam logic [31:0] A_STAT = 32'hC000_0000;
  localparam logic [31:0] A_DATA = 32'hC000_0004;
  localparam logic [31:0] A_CTRL = 32'hC000_0008;
  localparam logic [31:0] A_RSVD = 32'hC000_000C;
  localparam logic [31:0] A_OOR  = 32'h1000_0000;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  wa_we = 4'h0;
  logic [8:0]  rb_addr;
  logic [31:0] rb_dout;
  logic        IO_Addr_Strobe = 1'b0;
  logic        IO_Read_Strobe = 1'b0;
  logic        IO_Write_Strobe = 1'b0;
  logic [31:0] IO_Address = '0;
  logic [3:0]  IO_Byte_Enable = 4'hF;
  logic [31:0] IO_Write_Data = '0;
  logic [31:0] IO_Read_Data;
  logic        IO_Ready;

  logic [31:0] mem [512];
  logic [8:0]  wptr;
  logic [31:0] wa_din = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;
  int lat;

  iobus_event_reader #(.BASE_ADDR(32'hC000_0000), .DEPTH_LOG2(9)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .wa_we(wa_we), .rb_addr(rb_addr), .rb_dout(rb_dout),
    .IO_Addr_Strobe(IO_Addr_Strobe), .IO_Read_Strobe(IO_Read_Strobe),
    .IO_Write_Strobe(IO_Write_Strobe), .IO_Address(IO_Address),
    .IO_Byte_Enable(IO_Byte_Enable), .IO_Write_Data(IO_Write_Data),
    .IO_Read_Data(IO_Read_Data), .IO_Ready(IO_Ready)
  );

  always #5 Clk = ~Clk;

  // Capture-side writer and dual-port RAM with registered port B.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) wptr <= '0;
    else if (wa_we == 4'hF) begin
      mem[wptr] <= wa_din;
      wptr <= wptr + 9'd1;
    end
  end
  always @(posedge Clk) rb_dout <= mem[rb_addr];

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  task automatic snoop_writes(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      wa_we = 4'hF;
      wa_din = base + 32'(i);
      @(posedge Clk); #1;
    end
    wa_we = 4'h0;
  endtask

  task automatic io_access(input logic is_rd, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] data, output int cyc);
    IO_Addr_Strobe = 1'b1; IO_Read_Strobe = is_rd; IO_Write_Strobe = !is_rd;
    IO_Address = addr; IO_Write_Data = wd;
    @(posedge Clk); #1;
    IO_Addr_Strobe = 1'b0; IO_Read_Strobe = 1'b0; IO_Write_Strobe = 1'b0;
    cyc = 1;
    while (IO_Ready !== 1'b1 && cyc < 12) begin
      @(posedge Clk); #1;
      cyc++;
    end
    data = IO_Read_Data;
    if (cyc >= 12) cyc = 99;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #3;
    checks++; if (IO_Ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", IO_Ready); end
    checks++; if (IO_Read_Data !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", IO_Read_Data); end
    checks++; if (rb_addr !== 9'h0) begin failures++; $display("FAIL rst_rb_addr got=%h exp=0", rb_addr); end
    do_reset();
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL rst_stat_lat got=%0d exp=1", lat); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_stat got=%h exp=00000000", rd); end
  endtask

  task automatic test_fifo();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h0000_0A11; exp_w[1] = 32'h0000_0B22; exp_w[2] = 32'h0000_0C33;
    for (int i = 0; i < 3; i++) begin
      wa_we = 4'hF; wa_din = exp_w[i];
      @(posedge Clk); #1;
    end
    wa_we = 4'h0;
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL fifo_stat3 got=%h exp=00000003", rd); end
    for (int i = 0; i < 3; i++) begin
      io_access(1'b1, A_DATA, '0, rd, lat);
      checks++; if (rd !== exp_w[i]) begin failures++; $display("FAIL fifo_data%0d got=%h exp=%h", i, rd, exp_w[i]); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL fifo_lat%0d got=%0d exp=3", i, lat); end
    end
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL fifo_stat0 got=%h exp=00000000", rd); end
  endtask

  task automatic test_empty();
    io_access(1'b1, A_DATA, '0, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL empty_data got=%h exp=0", rd); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL empty_lat got=%0d exp=1", lat); end
    checks++; if (IO_Ready !== 1'b0 || IO_Read_Data !== 32'h0) begin
      failures++; $display("FAIL resp_release got ready=%b data=%h exp ready=0 data=0", IO_Ready, IO_Read_Data); end
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL empty_stat got=%h exp=0", rd); end
  endtask

  task automatic test_overflow();
    do_reset();
    snoop_writes(515, 32'h0000_1000);
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h8000_0200) begin failures++; $display("FAIL ovf_stat got=%h exp=80000200", rd); end
    io_access(1'b1, A_DATA, '0, rd, lat);
    checks++; if (rd !== 32'h0000_1003) begin failures++; $display("FAIL ovf_data got=%h exp=00001003", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL ovf_lat got=%0d exp=3", lat); end
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h8000_01FF) begin failures++; $display("FAIL ovf_stat2 got=%h exp=800001ff", rd); end
    io_access(1'b0, A_CTRL, 32'h2, rd, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL ctrl_lat got=%0d exp=1", lat); end
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h0000_01FF) begin failures++; $display("FAIL ovf_clr got=%h exp=000001ff", rd); end
    io_access(1'b1, A_RSVD, '0, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rsvd_rd got=%h exp=0", rd); end
    io_access(1'b1, A_OOR, '0, rd, lat);
    checks++; if (rd !== 32'h0 || lat !== 1) begin failures++; $display("FAIL oor_rd got=%h lat=%0d exp=0 lat=1", rd, lat); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    snoop_writes(512, 32'h0000_2000);
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h0000_0200) begin failures++; $display("FAIL b2b_full got=%h exp=00000200", rd); end
    // DATA read with a write in the pop cycle (cycle 2).
    IO_Addr_Strobe = 1'b1; IO_Read_Strobe = 1'b1; IO_Address = A_DATA;
    @(posedge Clk); #1;
    IO_Addr_Strobe = 1'b0; IO_Read_Strobe = 1'b0;
    @(posedge Clk); #1;
    wa_we = 4'hF; wa_din = 32'h0000_2200;
    @(posedge Clk); #1;
    wa_we = 4'h0;
    n = 0;
    while (IO_Ready !== 1'b1 && n < 10) begin @(posedge Clk); #1; n++; end
    checks++; if (n !== 0) begin failures++; $display("FAIL b2b_lat extra_cycles=%0d exp=0", n); end
    checks++; if (IO_Read_Data !== 32'h0000_2000) begin failures++; $display("FAIL b2b_data got=%h exp=00002000", IO_Read_Data); end
    @(posedge Clk); #1;
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h0000_0200) begin failures++; $display("FAIL b2b_stat got=%h exp=00000200", rd); end
    io_access(1'b1, A_DATA, '0, rd, lat);
    checks++; if (rd !== 32'h0000_2001) begin failures++; $display("FAIL b2b_data2 got=%h exp=00002001", rd); end
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h0000_01FF) begin failures++; $display("FAIL b2b_stat2 got=%h exp=000001ff", rd); end
  endtask

  task automatic test_flush();
    do_reset();
    snoop_writes(5, 32'h0000_3000);
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h5) begin failures++; $display("FAIL flush_pre got=%h exp=00000005", rd); end
    io_access(1'b0, A_CTRL, 32'h1, rd, lat);
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL flush_stat got=%h exp=00000000", rd); end
    io_access(1'b1, A_DATA, '0, rd, lat);
    checks++; if (lat !== 1 || rd !== 32'h0) begin failures++; $display("FAIL flush_empty got=%h lat=%0d exp=0 lat=1", rd, lat); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    snoop_writes(2, 32'h0000_4000);
    IO_Addr_Strobe = 1'b1; IO_Read_Strobe = 1'b1; IO_Address = A_DATA;
    @(posedge Clk); #1;
    IO_Addr_Strobe = 1'b0; IO_Read_Strobe = 1'b0;
    Reset_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      if (IO_Ready !== 1'b0) seen = 1'b1;
    end
    checks++; if (rb_addr !== 9'h0) begin failures++; $display("FAIL midrst_rb_addr got=%h exp=0", rb_addr); end
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      if (IO_Ready !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_ready got=1 exp=0"); end
    io_access(1'b1, A_STAT, '0, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL midrst_stat got=%h exp=00000000", rd); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_fifo();
    test_empty();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
